// File: rtl/neuron_scheduler.sv
// neuron_scheduler
//   Time-multiplexes one shared LIF neuron datapath across N_NEURONS logical
//   neurons. Per-neuron membrane potential and last-spike flag live here,
//   together with the layer config (decay shift, negated threshold). A start
//   in IDLE runs one timestep. Each RUN cycle serves one neuron, and the
//   datapath result is written back on the same edge. The layer spike vector
//   is published with a one-cycle done pulse.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start, x_in                timestep request and input spike vector (IDLE only)
//   clear_state                IDLE only: zero potentials, spike flags, step_cnt
//   cfg_we, cfg_shift,
//   cfg_minus_teta             IDLE only: load layer config
//   w_addr / w_data            weight-row index out, weight row in (combinational)
//   neu_*  (out)               operands for the shared neuron, selected by idx
//   neu_u_out, neu_is_spike    datapath results (combinational)
//   busy, done                 RUN indicator, end-of-timestep pulse
//   spikes_out                 layer spike vector, held until the next done
//   step_cnt                   completed timesteps, 8-bit wrap
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; config load and state clear accepted here
// RUN   | one neuron per cycle, idx 0..N_NEURONS-1, result written back
// DONE  | one cycle: done pulse, step_cnt increments

module neuron_scheduler #(
    parameter  int n_stage   = 2,
    parameter  int N_NEURONS = 4,
    localparam int NI        = 2 ** n_stage,
    localparam int UW        = n_stage + 2,
    localparam int IW        = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NI-1:0]        x_in,
    input  logic                 clear_state,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_shift,
    input  logic [UW-1:0]        cfg_minus_teta,
    output logic [IW-1:0]        w_addr,
    input  logic [NI-1:0]        w_data,
    output logic [NI-1:0]        neu_w,
    output logic [NI-1:0]        neu_x,
    output logic [2:0]           neu_shift,
    output logic [UW-1:0]        neu_minus_teta,
    output logic [UW-1:0]        neu_previus_u,
    output logic                 neu_was_spike,
    input  logic [UW-1:0]        neu_u_out,
    input  logic                 neu_is_spike,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes_out,
    output logic [7:0]           step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(N_NEURONS - 1);

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NI-1:0]          x_q, x_d;
    logic [2:0]             shift_q, shift_d;
    logic [UW-1:0]          teta_q, teta_d;
    logic [UW-1:0]          u_mem_q [N_NEURONS];
    logic [UW-1:0]          u_mem_d [N_NEURONS];
    logic [N_NEURONS-1:0]   spk_mem_q, spk_mem_d;
    logic [N_NEURONS-1:0]   spikes_q, spikes_d;
    logic [7:0]             step_cnt_q, step_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            shift_q    <= '0;
            teta_q     <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                u_mem_q[i] <= '0;
            end
            spk_mem_q  <= '0;
            spikes_q   <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            shift_q    <= shift_d;
            teta_q     <= teta_d;
            u_mem_q    <= u_mem_d;
            spk_mem_q  <= spk_mem_d;
            spikes_q   <= spikes_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        shift_d    = shift_q;
        teta_d     = teta_q;
        u_mem_d    = u_mem_q;
        spk_mem_d  = spk_mem_q;
        spikes_d   = spikes_q;
        step_cnt_d = step_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Config and clear land on the same edge as an accepted start,
                // so that run already sees the new config and cleared state.
                if (cfg_we) begin
                    shift_d = cfg_shift;
                    teta_d  = cfg_minus_teta;
                end
                if (clear_state) begin
                    for (int i = 0; i < N_NEURONS; i++) begin
                        u_mem_d[i] = '0;
                    end
                    spk_mem_d  = '0;
                    step_cnt_d = '0;
                end
                if (start) begin
                    x_d     = x_in;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                u_mem_d[idx_q]   = neu_u_out;
                spk_mem_d[idx_q] = neu_is_spike;
                if (idx_q == IDX_LAST) begin
                    idx_d    = '0;
                    // Take the snapshot including the final writeback, so it
                    // is already valid during the done cycle.
                    spikes_d = spk_mem_d;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                step_cnt_d = step_cnt_q + 8'd1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // idx is held at 0 outside RUN, so these give the neuron-0 view there.
    assign w_addr         = idx_q;
    assign neu_w          = w_data;
    assign neu_x          = x_q;
    assign neu_shift      = shift_q;
    assign neu_minus_teta = teta_q;
    assign neu_previus_u  = u_mem_q[idx_q];
    assign neu_was_spike  = spk_mem_q[idx_q];

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign spikes_out = spikes_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Directed bench for neuron_scheduler (n_stage=2, N_NEURONS=4).
// A LIF neuron stub closes the loop on the neu_* ports. A shadow copy of the
// per-neuron potentials and spike flags provides the expected values.
module tb_neuron_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] x_in;
    logic       clear_state;
    logic       cfg_we;
    logic [2:0] cfg_shift;
    logic [3:0] cfg_minus_teta;
    logic [1:0] w_addr;
    logic [3:0] w_data;
    logic [3:0] neu_w;
    logic [3:0] neu_x;
    logic [2:0] neu_shift;
    logic [3:0] neu_minus_teta;
    logic [3:0] neu_previus_u;
    logic       neu_was_spike;
    logic [3:0] neu_u_out;
    logic       neu_is_spike;
    logic       busy;
    logic       done;
    logic [3:0] spikes_out;
    logic [7:0] step_cnt;

    int checks   = 0;
    int failures = 0;

    logic [3:0] wrom [4];
    logic [3:0] sh_u [4];
    logic [3:0] sh_s;
    logic [2:0] e_shift;
    logic [3:0] e_teta;
    logic [7:0] e_cnt;
    logic [4:0] stub_r;

    always #5 clk = ~clk;

    neuron_scheduler #(.n_stage(2), .N_NEURONS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .x_in           (x_in),
        .clear_state    (clear_state),
        .cfg_we         (cfg_we),
        .cfg_shift      (cfg_shift),
        .cfg_minus_teta (cfg_minus_teta),
        .w_addr         (w_addr),
        .w_data         (w_data),
        .neu_w          (neu_w),
        .neu_x          (neu_x),
        .neu_shift      (neu_shift),
        .neu_minus_teta (neu_minus_teta),
        .neu_previus_u  (neu_previus_u),
        .neu_was_spike  (neu_was_spike),
        .neu_u_out      (neu_u_out),
        .neu_is_spike   (neu_is_spike),
        .busy           (busy),
        .done           (done),
        .spikes_out     (spikes_out),
        .step_cnt       (step_cnt)
    );

    // LIF neuron: reset-to-zero after a spike, leak u - (u >>> shift),
    // add popcount(w & x), spike when u + minus_teta >= 0. Returns {spike, u}.
    function automatic logic [4:0] lif(input logic [3:0] prev, input logic was,
                                       input logic [3:0] w, input logic [3:0] x,
                                       input logic [2:0] sh, input logic [3:0] te);
        logic signed [3:0] p, acc, th;
        logic [3:0] m, pc;
        p   = prev;
        m   = w & x;
        pc  = 4'(m[0]) + 4'(m[1]) + 4'(m[2]) + 4'(m[3]);
        acc = was ? 4'sd0 : (p - (p >>> sh));
        acc = acc + $signed(pc);
        th  = acc + $signed(te);
        return th[3] ? {1'b0, acc} : {1'b1, 4'b0000};
    endfunction

    assign w_data = wrom[w_addr];
    always_comb stub_r = lif(neu_previus_u, neu_was_spike, neu_w, neu_x, neu_shift, neu_minus_teta);
    assign neu_u_out    = stub_r[3:0];
    assign neu_is_spike = stub_r[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < 4; i++) sh_u[i] = 4'h0;
        sh_s = 4'h0;
    endtask

    // Called at the sample point of an IDLE cycle t; returns at t+6 (IDLE).
    task automatic run_step(input logic [3:0] xv, input bit cfg_en, input bit clr_en,
                            input logic [2:0] sh, input logic [3:0] te,
                            input bit hold, input bit disturb);
        logic [4:0] r;
        chk("idle_busy", 32'(busy), 32'd0);
        start          = 1'b1;
        x_in           = xv;
        cfg_we         = cfg_en;
        clear_state    = clr_en;
        cfg_shift      = sh;
        cfg_minus_teta = te;
        if (cfg_en) begin
            e_shift = sh;
            e_teta  = te;
        end
        if (clr_en) begin
            clear_shadow();
            e_cnt = 8'd0;
        end
        tick();
        if (!hold) start = 1'b0;
        cfg_we      = 1'b0;
        clear_state = 1'b0;
        x_in        = ~xv;
        for (int j = 0; j < 4; j++) begin
            if (disturb && j == 1) begin
                start          = 1'b1;
                cfg_we         = 1'b1;
                clear_state    = 1'b1;
                cfg_shift      = 3'd7;
                cfg_minus_teta = 4'h7;
            end
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("w_addr", 32'(w_addr), 32'(j));
            chk("neu_x", 32'(neu_x), 32'(xv));
            chk("neu_w", 32'(neu_w), 32'(wrom[j]));
            chk("neu_shift", 32'(neu_shift), 32'(e_shift));
            chk("neu_minus_teta", 32'(neu_minus_teta), 32'(e_teta));
            chk("neu_previus_u", 32'(neu_previus_u), 32'(sh_u[j]));
            chk("neu_was_spike", 32'(neu_was_spike), 32'(sh_s[j]));
            r        = lif(sh_u[j], sh_s[j], wrom[j], xv, e_shift, e_teta);
            sh_u[j]  = r[3:0];
            sh_s[j]  = r[4];
            if (disturb && j == 3) begin
                start       = 1'b0;
                cfg_we      = 1'b0;
                clear_state = 1'b0;
            end
            tick();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_spikes", 32'(spikes_out), 32'(sh_s));
        chk("done_w_addr", 32'(w_addr), 32'd0);
        e_cnt = e_cnt + 8'd1;
        tick();
        chk("after_done", 32'(done), 32'd0);
        chk("step_cnt", 32'(step_cnt), 32'(e_cnt));
        chk("spikes_held", 32'(spikes_out), 32'(sh_s));
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        x_in           = 4'h0;
        clear_state    = 1'b0;
        cfg_we         = 1'b0;
        cfg_shift      = 3'd0;
        cfg_minus_teta = 4'h0;
        for (int i = 0; i < 4; i++) wrom[i] = 4'hF;
        clear_shadow();
        e_shift = 3'd0;
        e_teta  = 4'h0;
        e_cnt   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_spikes", 32'(spikes_out), 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_prev_u", 32'(neu_previus_u), 32'd0);
        chk("rst_was_spike", 32'(neu_was_spike), 32'd0);
        chk("rst_teta", 32'(neu_minus_teta), 32'd0);

        // 1: all-ones inputs and weights, shift 0, minus_teta -4 -> every neuron
        // reaches 4, fires and resets to 0.
        cfg_we = 1'b1; cfg_shift = 3'd0; cfg_minus_teta = 4'hC;
        e_shift = 3'd0; e_teta = 4'hC;
        tick();
        cfg_we = 1'b0;
        run_step(4'hF, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        chk("t1_spikes_all", 32'(spikes_out), 32'hF);

        // 3: spiking step with graded weights, then three silent steps.
        wrom[0] = 4'hF; wrom[1] = 4'h7; wrom[2] = 4'h3; wrom[3] = 4'h1;
        run_step(4'hF, 1'b1, 1'b0, 3'd1, 4'hD, 1'b0, 1'b0);
        chk("t3_spikes_01", 32'(spikes_out), 32'h3);
        for (int k = 0; k < 3; k++) run_step(4'h0, 1'b0, 1'b0, 3'd1, 4'hD, 1'b0, 1'b0);
        chk("t3_silent", 32'(spikes_out), 32'h0);

        // 2: start held high; each run starts in the cycle after the previous one finishes.
        run_step(4'hA, 1'b0, 1'b0, 3'd1, 4'hD, 1'b1, 1'b0);
        run_step(4'hA, 1'b0, 1'b0, 3'd1, 4'hD, 1'b1, 1'b0);
        run_step(4'hA, 1'b0, 1'b0, 3'd1, 4'hD, 1'b0, 1'b0);

        // 4: start + cfg_we + clear in one IDLE cycle.
        run_step(4'hF, 1'b1, 1'b1, 3'd2, 4'hE, 1'b0, 1'b0);
        chk("t4_cnt_after_clear", 32'(step_cnt), 32'd1);

        // 5: cfg_we, clear and start pulsed during RUN are ignored.
        run_step(4'h6, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1);
        tick();
        chk("t5_no_extra_run", 32'(busy), 32'd0);
        chk("t5_cfg_kept", 32'(neu_minus_teta), 32'hE);

        // 6: reset in the middle of a run.
        start = 1'b1; x_in = 4'hF;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_spikes", 32'(spikes_out), 32'd0);
        chk("mid_rst_cnt", 32'(step_cnt), 32'd0);
        chk("mid_rst_teta", 32'(neu_minus_teta), 32'd0);
        chk("mid_rst_shift", 32'(neu_shift), 32'd0);
        clear_shadow();
        e_shift = 3'd0;
        e_teta  = 4'h0;
        e_cnt   = 8'd0;
        for (int k = 0; k < 255; k++) run_step(4'h9, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        chk("cnt_255", 32'(step_cnt), 32'd255);
        run_step(4'h9, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
        chk("cnt_wrap", 32'(step_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
